// File: rtl/time_of_day_core.sv
// time_of_day_core
//   Time-of-day clock. A prescaler divides clk down to a one-second tick that
//   advances six BCD digits held in 24-hour form. Hours are shown either as
//   24-hour or 12-hour (with pm) without touching the stored time. A load
//   request sets the time after range checking; a bad request is dropped and
//   flagged.
//
// Parameters
//   DIV    clk cycles per one-second tick (>= 1)
//   DIV_W  prescaler width, 2**DIV_W >= DIV
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   en                 count enable (freezes prescaler and time when low)
//   mode_12h           1 = 12-hour display with pm flag, 0 = 24-hour
//   load, load_*       single-cycle time set request, BCD 24-hour data
//   sec_*, min_*       registered BCD seconds / minutes digits
//   hr_10, hr_1        displayed BCD hour digits (mode dependent)
//   pm                 registered, high when stored hour >= 12
//   day_pulse          one-cycle pulse after 23:59:59 -> 00:00:00
//   load_err           one-cycle pulse after a rejected load
module time_of_day_core #(
  parameter int DIV   = 50000000,
  parameter int DIV_W = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode_12h,
  input  logic       load,
  input  logic [1:0] load_hr10,
  input  logic [3:0] load_hr1,
  input  logic [2:0] load_min10,
  input  logic [3:0] load_min1,
  input  logic [2:0] load_sec10,
  input  logic [3:0] load_sec1,
  output logic [3:0] sec_1,
  output logic [2:0] sec_10,
  output logic [3:0] min_1,
  output logic [2:0] min_10,
  output logic [3:0] hr_1,
  output logic [1:0] hr_10,
  output logic       pm,
  output logic       day_pulse,
  output logic       load_err
);

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

  // Range check of a 24-hour BCD time.
  function automatic logic time_is_valid(
    input logic [1:0] h10, input logic [3:0] h1,
    input logic [2:0] m10, input logic [3:0] m1,
    input logic [2:0] s10, input logic [3:0] s1
  );
    return (h10 <= 2'd2) && (h1 <= 4'd9) && !((h10 == 2'd2) && (h1 > 4'd3)) &&
           (m10 <= 3'd5) && (m1 <= 4'd9) && (s10 <= 3'd5) && (s1 <= 4'd9);
  endfunction

  // Afternoon test on a 24-hour BCD hour.
  function automatic logic hour_is_pm(input logic [1:0] h10, input logic [3:0] h1);
    return (h10 == 2'd2) || ((h10 == 2'd1) && (h1 >= 4'd2));
  endfunction

  logic [DIV_W-1:0] presc_r, presc_n;
  logic [3:0] sec_1_r, sec_1_n;
  logic [2:0] sec_10_r, sec_10_n;
  logic [3:0] min_1_r, min_1_n;
  logic [2:0] min_10_r, min_10_n;
  logic [3:0] hr_1_r, hr_1_n;
  logic [1:0] hr_10_r, hr_10_n;
  logic       pm_r, day_pulse_r, load_err_r;
  logic       load_ok_s, load_bad_s, tick_s, at_day_end_s, rollover_s;

  assign load_ok_s  = load & time_is_valid(load_hr10, load_hr1, load_min10,
                                           load_min1, load_sec10, load_sec1);
  assign load_bad_s = load & ~load_ok_s;
  // A valid load owns the cycle: the tick that would have fired is dropped.
  assign tick_s     = en & (presc_r == PRESC_LAST) & ~load_ok_s;
  assign at_day_end_s = (hr_10_r == 2'd2) && (hr_1_r == 4'd3) &&
                        (min_10_r == 3'd5) && (min_1_r == 4'd9) &&
                        (sec_10_r == 3'd5) && (sec_1_r == 4'd9);
  assign rollover_s = tick_s & at_day_end_s;

  // Next prescaler and time: load, else tick with BCD carry chain, else hold.
  always_comb begin
    presc_n  = presc_r;
    sec_1_n  = sec_1_r;
    sec_10_n = sec_10_r;
    min_1_n  = min_1_r;
    min_10_n = min_10_r;
    hr_1_n   = hr_1_r;
    hr_10_n  = hr_10_r;
    if (load_ok_s) begin
      presc_n  = '0;
      sec_1_n  = load_sec1;
      sec_10_n = load_sec10;
      min_1_n  = load_min1;
      min_10_n = load_min10;
      hr_1_n   = load_hr1;
      hr_10_n  = load_hr10;
    end else if (tick_s) begin
      presc_n = '0;
      if (sec_1_r != 4'd9) begin
        sec_1_n = sec_1_r + 4'd1;
      end else begin
        sec_1_n = 4'd0;
        if (sec_10_r != 3'd5) begin
          sec_10_n = sec_10_r + 3'd1;
        end else begin
          sec_10_n = 3'd0;
          if (min_1_r != 4'd9) begin
            min_1_n = min_1_r + 4'd1;
          end else begin
            min_1_n = 4'd0;
            if (min_10_r != 3'd5) begin
              min_10_n = min_10_r + 3'd1;
            end else begin
              min_10_n = 3'd0;
              if ((hr_10_r == 2'd2) && (hr_1_r == 4'd3)) begin
                hr_10_n = 2'd0;
                hr_1_n  = 4'd0;
              end else if (hr_1_r == 4'd9) begin
                hr_1_n  = 4'd0;
                hr_10_n = hr_10_r + 2'd1;
              end else begin
                hr_1_n = hr_1_r + 4'd1;
              end
            end
          end
        end
      end
    end else if (en) begin
      presc_n = presc_r + DIV_W'(1);
    end else begin
      presc_n = presc_r;
    end
  end

  // State registers; pm is registered from the next hour so it needs no decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r     <= '0;
      sec_1_r     <= 4'd0;
      sec_10_r    <= 3'd0;
      min_1_r     <= 4'd0;
      min_10_r    <= 3'd0;
      hr_1_r      <= 4'd0;
      hr_10_r     <= 2'd0;
      pm_r        <= 1'b0;
      day_pulse_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      presc_r     <= presc_n;
      sec_1_r     <= sec_1_n;
      sec_10_r    <= sec_10_n;
      min_1_r     <= min_1_n;
      min_10_r    <= min_10_n;
      hr_1_r      <= hr_1_n;
      hr_10_r     <= hr_10_n;
      pm_r        <= hour_is_pm(hr_10_n, hr_1_n);
      day_pulse_r <= rollover_s;
      load_err_r  <= load_bad_s;
    end
  end

  // Hour display mapping; 12-hour mode folds 00 -> 12 and 13..23 -> 01..11.
  always_comb begin
    hr_10 = hr_10_r;
    hr_1  = hr_1_r;
    if (mode_12h) begin
      if ((hr_10_r == 2'd0) && (hr_1_r == 4'd0)) begin
        hr_10 = 2'd1;
        hr_1  = 4'd2;
      end else if ((hr_10_r == 2'd1) && (hr_1_r >= 4'd3)) begin
        hr_10 = 2'd0;
        hr_1  = hr_1_r - 4'd2;
      end else if ((hr_10_r == 2'd2) && (hr_1_r <= 4'd1)) begin
        hr_10 = 2'd0;
        hr_1  = hr_1_r + 4'd8;
      end else if (hr_10_r == 2'd2) begin
        hr_10 = 2'd1;
        hr_1  = hr_1_r - 4'd2;
      end else begin
        hr_10 = hr_10_r;
        hr_1  = hr_1_r;
      end
    end else begin
      hr_10 = hr_10_r;
      hr_1  = hr_1_r;
    end
  end

  assign sec_1     = sec_1_r;
  assign sec_10    = sec_10_r;
  assign min_1     = min_1_r;
  assign min_10    = min_10_r;
  assign pm        = pm_r;
  assign day_pulse = day_pulse_r;
  assign load_err  = load_err_r;

endmodule

// File: tb/tb_time_of_day_core.sv
// Scoreboard bench for time_of_day_core with DIV=4. Stimulus pushes expected
// output snapshots stamped with the cycle at which they must hold; a monitor
// pops and compares them on the falling edge (or on an explicit sample event
// for the asynchronous reset check).
module tb_time_of_day_core;

  logic       clk = 1'b0;
  logic       rst_n, en, mode_12h, load;
  logic [1:0] load_hr10;
  logic [3:0] load_hr1;
  logic [2:0] load_min10;
  logic [3:0] load_min1;
  logic [2:0] load_sec10;
  logic [3:0] load_sec1;
  logic [3:0] sec_1, min_1, hr_1;
  logic [2:0] sec_10, min_10;
  logic [1:0] hr_10;
  logic       pm, day_pulse, load_err;

  time_of_day_core #(.DIV(4), .DIV_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode_12h(mode_12h), .load(load),
    .load_hr10(load_hr10), .load_hr1(load_hr1), .load_min10(load_min10),
    .load_min1(load_min1), .load_sec10(load_sec10), .load_sec1(load_sec1),
    .sec_1(sec_1), .sec_10(sec_10), .min_1(min_1), .min_10(min_10),
    .hr_1(hr_1), .hr_10(hr_10), .pm(pm), .day_pulse(day_pulse),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          stamp;
    logic [22:0] exp;
    string       name;
  } entry_t;

  entry_t sb[$];
  int     n_vec = 0;
  int     n_bad = 0;
  event   sample_ev;

  // {hr_10, hr_1, min_10, min_1, sec_10, sec_1, pm, day_pulse, load_err}
  function automatic logic [22:0] pk(input int h10, input int h1, input int m10,
                                     input int m1, input int s10, input int s1,
                                     input logic p, input logic dp, input logic le);
    return {2'(h10), 4'(h1), 3'(m10), 4'(m1), 3'(s10), 4'(s1), p, dp, le};
  endfunction

  function automatic string fmt(input logic [22:0] v);
    return $sformatf("%0d%0d:%0d%0d:%0d%0d pm=%b dp=%b err=%b",
                     v[22:21], v[20:17], v[16:14], v[13:10], v[9:7], v[6:3],
                     v[2], v[1], v[0]);
  endfunction

  task automatic push(input string nm, input int k, input logic [22:0] e);
    entry_t ent;
    ent.stamp = cyc + k;
    ent.exp   = e;
    ent.name  = nm;
    sb.push_back(ent);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_load(input int h10, input int h1, input int m10,
                          input int m1, input int s10, input int s1);
    load       = 1'b1;
    load_hr10  = 2'(h10);
    load_hr1   = 4'(h1);
    load_min10 = 3'(m10);
    load_min1  = 4'(m1);
    load_sec10 = 3'(s10);
    load_sec1  = 4'(s1);
  endtask

  // Monitor: compare every snapshot whose stamp has been reached.
  initial begin
    entry_t      ent;
    logic [22:0] act;
    forever begin
      @(negedge clk or sample_ev);
      while (sb.size() > 0 && sb[0].stamp <= cyc) begin
        ent = sb.pop_front();
        act = {hr_10, hr_1, min_10, min_1, sec_10, sec_1, pm, day_pulse, load_err};
        n_vec++;
        if (act !== ent.exp) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got %s want %s", ent.name, cyc, fmt(act), fmt(ent.exp));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  int bad_tbl[4][6] = '{'{0, 0, 0, 10, 0, 0}, '{2, 4, 0, 0, 0, 0},
                        '{3, 0, 0, 0, 0, 0},  '{0, 0, 0, 0, 6, 0}};

  initial begin
    rst_n = 1'b0; en = 1'b0; mode_12h = 1'b0;
    load = 1'b0; load_hr10 = 2'd0; load_hr1 = 4'd0; load_min10 = 3'd0;
    load_min1 = 4'd0; load_sec10 = 3'd0; load_sec1 = 4'd0;
    step(2);
    push("reset_hold", 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1);

    // Count from reset: first second after 4 edges, a minute after 240.
    rst_n = 1'b1; en = 1'b1;
    push("first_sec_pre", 3, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    push("first_sec", 4, pk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    push("min_pre", 239, pk(0, 0, 0, 0, 5, 9, 0, 0, 0));
    push("min_roll", 240, pk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    step(240);

    // Freeze: 22 is not a multiple of DIV, so a running prescaler would show.
    en = 1'b0;
    push("freeze", 22, pk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    step(22);
    en = 1'b1;
    push("resume_pre", 3, pk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    push("resume", 4, pk(0, 0, 0, 1, 0, 1, 0, 0, 0));
    step(4);

    // Day rollover.
    set_load(2, 3, 5, 9, 5, 8);
    push("ld_235958", 1, pk(2, 3, 5, 9, 5, 8, 1, 0, 0));
    push("pre_roll", 5, pk(2, 3, 5, 9, 5, 9, 1, 0, 0));
    push("pre_roll_end", 8, pk(2, 3, 5, 9, 5, 9, 1, 0, 0));
    push("day_roll", 9, pk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    push("day_once", 10, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1);
    load = 1'b0;
    step(9);

    // Load in the prescaler==3 cycle (prescaler is 1 here, two edges to go).
    step(2);
    set_load(1, 2, 3, 4, 5, 6);
    push("ld_at_tick", 1, pk(1, 2, 3, 4, 5, 6, 1, 0, 0));
    push("no_early_tick", 4, pk(1, 2, 3, 4, 5, 6, 1, 0, 0));
    push("tick_4_later", 5, pk(1, 2, 3, 4, 5, 7, 1, 0, 0));
    step(1);
    load = 1'b0;
    step(4);

    // Asynchronous reset observed between clock edges.
    rst_n = 1'b0;
    push("async_rst", 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    -> sample_ev;
    step(1);
    rst_n = 1'b1; en = 1'b1;
    push("rst_resume_pre", 3, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    push("rst_resume", 4, pk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    step(4);
    en = 1'b0;

    // 12-hour display mapping.
    mode_12h = 1'b1;
    set_load(1, 3, 0, 5, 0, 0);
    push("h12_13", 1, pk(0, 1, 0, 5, 0, 0, 1, 0, 0));
    step(1); load = 1'b0;
    set_load(2, 0, 0, 0, 0, 0);
    push("h12_20", 1, pk(0, 8, 0, 0, 0, 0, 1, 0, 0));
    step(1); load = 1'b0;
    set_load(2, 3, 5, 9, 5, 9);
    push("h12_23", 1, pk(1, 1, 5, 9, 5, 9, 1, 0, 0));
    step(1); load = 1'b0;
    set_load(1, 2, 0, 0, 0, 0);
    push("h12_12", 1, pk(1, 2, 0, 0, 0, 0, 1, 0, 0));
    step(1); load = 1'b0;
    set_load(0, 0, 3, 0, 0, 0);
    push("h12_00", 1, pk(1, 2, 3, 0, 0, 0, 0, 0, 0));
    step(1); load = 1'b0;
    mode_12h = 1'b0;
    push("mode_24", 1, pk(0, 0, 3, 0, 0, 0, 0, 0, 0));
    step(1);

    // Rejected loads: time kept, load_err for exactly one cycle.
    for (int i = 0; i < 4; i++) begin
      set_load(bad_tbl[i][0], bad_tbl[i][1], bad_tbl[i][2],
               bad_tbl[i][3], bad_tbl[i][4], bad_tbl[i][5]);
      push($sformatf("bad_ld%0d_err", i), 1, pk(0, 0, 3, 0, 0, 0, 0, 0, 1));
      push($sformatf("bad_ld%0d_clr", i), 2, pk(0, 0, 3, 0, 0, 0, 0, 0, 0));
      step(1); load = 1'b0;
      step(1);
    end

    // Loading midnight does not count as a rollover.
    set_load(0, 0, 0, 0, 0, 0);
    push("ld_midnight", 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1); load = 1'b0;

    // Load 23:59:59 over a due tick: tick dropped, no day_pulse.
    set_load(2, 3, 5, 9, 5, 9);
    push("ld_2359_a", 1, pk(2, 3, 5, 9, 5, 9, 1, 0, 0));
    step(1); load = 1'b0;
    en = 1'b1;
    step(3);
    set_load(2, 3, 5, 9, 5, 9);
    push("ld_over_tick", 1, pk(2, 3, 5, 9, 5, 9, 1, 0, 0));
    push("ld_no_pulse", 2, pk(2, 3, 5, 9, 5, 9, 1, 0, 0));
    push("roll_after_ld", 5, pk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(1); load = 1'b0;
    step(4);

    step(3);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
